// File: rtl/digit_entry.sv
// Keypad digit entry: collects up to MAX_DIGITS BCD digits with backspace and
// clear editing, then converts the buffer to binary on enter. The conversion
// runs one digit per cycle, most significant (first-typed) digit first.
module digit_entry #(
  parameter int MAX_DIGITS = 4,
  parameter int VALUE_W    = 14
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    key_valid,
  input  logic [4:0]              key_code,
  output logic                    key_ready,
  output logic [4*MAX_DIGITS-1:0] numbers,
  output logic [2:0]              digit_count,
  output logic [VALUE_W-1:0]      value,
  output logic                    value_valid,
  output logic                    key_error
);

  localparam logic [4:0] KEY_BACKSPACE = 5'h10;
  localparam logic [4:0] KEY_CLEAR     = 5'h11;
  localparam logic [4:0] KEY_ENTER     = 5'h12;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [4*MAX_DIGITS-1:0] numbers_q, numbers_d;
  logic [2:0]              digit_count_q, digit_count_d;
  logic [2:0]              idx_q, idx_d;
  logic [VALUE_W-1:0]      acc_q, acc_d;
  logic [VALUE_W-1:0]      value_q, value_d;
  logic                    value_valid_q, value_valid_d;
  logic                    key_error_q, key_error_d;
  logic                    key_ready_q, key_ready_d;

  logic                    accept;
  logic [3:0]              cur_digit;
  logic [VALUE_W-1:0]      acc_next;

  // Next-state, buffer editing and conversion datapath.
  always_comb begin
    state_d       = state_q;
    numbers_d     = numbers_q;
    digit_count_d = digit_count_q;
    idx_d         = idx_q;
    acc_d         = acc_q;
    value_d       = value_q;
    value_valid_d = 1'b0;
    key_error_d   = 1'b0;

    accept = key_valid && key_ready_q;

    // Digit under the conversion index, selected with constant slices.
    cur_digit = '0;
    for (int unsigned k = 0; k < MAX_DIGITS; k++) begin
      if (idx_q == 3'(k)) cur_digit = numbers_q[4*k +: 4];
    end
    acc_next = acc_q * VALUE_W'(10) + VALUE_W'(cur_digit);

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          if (key_code <= 5'h09) begin
            if (digit_count_q < 3'(MAX_DIGITS)) begin
              for (int unsigned k = 0; k < MAX_DIGITS; k++) begin
                if (digit_count_q == 3'(k)) numbers_d[4*k +: 4] = key_code[3:0];
              end
              digit_count_d = digit_count_q + 3'd1;
            end else begin
              key_error_d = 1'b1;
            end
          end else if (key_code == KEY_BACKSPACE) begin
            if (digit_count_q != 3'd0) begin
              for (int unsigned k = 0; k < MAX_DIGITS; k++) begin
                if (digit_count_q == 3'(k + 1)) numbers_d[4*k +: 4] = 4'h0;
              end
              digit_count_d = digit_count_q - 3'd1;
            end else begin
              key_error_d = 1'b1;
            end
          end else if (key_code == KEY_CLEAR) begin
            numbers_d     = '0;
            digit_count_d = '0;
          end else if (key_code == KEY_ENTER) begin
            acc_d = '0;
            idx_d = '0;
            if (digit_count_q == 3'd0) begin
              // Empty buffer skips CONVERT; DONE publishes the cleared accumulator.
              state_d       = DONE;
              value_d       = '0;
              value_valid_d = 1'b1;
            end else begin
              state_d = CONVERT;
            end
          end else begin
            key_error_d = 1'b1;
          end
        end
      end
      CONVERT: begin
        acc_d = acc_next;
        idx_d = idx_q + 3'd1;
        // value/value_valid are registered, so they are loaded on the edge
        // entering DONE and are visible for exactly the DONE cycle.
        if (idx_q + 3'd1 == digit_count_q) begin
          state_d       = DONE;
          value_d       = acc_next;
          value_valid_d = 1'b1;
        end
      end
      DONE: begin
        numbers_d     = '0;
        digit_count_d = '0;
        state_d       = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    key_ready_d = (state_d == IDLE);
  end

  // State and registered outputs; reset forces everything idle and not ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      numbers_q     <= '0;
      digit_count_q <= '0;
      idx_q         <= '0;
      acc_q         <= '0;
      value_q       <= '0;
      value_valid_q <= 1'b0;
      key_error_q   <= 1'b0;
      key_ready_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      numbers_q     <= numbers_d;
      digit_count_q <= digit_count_d;
      idx_q         <= idx_d;
      acc_q         <= acc_d;
      value_q       <= value_d;
      value_valid_q <= value_valid_d;
      key_error_q   <= key_error_d;
      key_ready_q   <= key_ready_d;
    end
  end

  assign key_ready   = key_ready_q;
  assign numbers     = numbers_q;
  assign digit_count = digit_count_q;
  assign value       = value_q;
  assign value_valid = value_valid_q;
  assign key_error   = key_error_q;

endmodule

// File: tb/tb_digit_entry.sv
// Self-checking bench for digit_entry: a table of key presses with expected
// buffer state, a scoreboard of expected converted values, and hand-written
// backpressure and mid-conversion reset sequences.
module tb_digit_entry;

  localparam int MAX_DIGITS = 4;
  localparam int VALUE_W    = 14;

  logic                    clk = 1'b0;
  logic                    rst_n = 1'b1;
  logic                    key_valid = 1'b0;
  logic [4:0]              key_code = '0;
  logic                    key_ready;
  logic [4*MAX_DIGITS-1:0] numbers;
  logic [2:0]              digit_count;
  logic [VALUE_W-1:0]      value;
  logic                    value_valid;
  logic                    key_error;

  digit_entry #(.MAX_DIGITS(MAX_DIGITS), .VALUE_W(VALUE_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_valid   (key_valid),
    .key_code    (key_code),
    .key_ready   (key_ready),
    .numbers     (numbers),
    .digit_count (digit_count),
    .value       (value),
    .value_valid (value_valid),
    .key_error   (key_error)
  );

  always #5 clk = ~clk;

  int unsigned total  = 0;
  int unsigned passed = 0;
  int unsigned vv_count = 0;
  logic [VALUE_W-1:0] sb[$];

  typedef struct {
    logic [4:0]  code;
    bit          ent;
    logic [15:0] nums;
    logic [2:0]  cnt;
    bit          err;
    logic [13:0] val;
    int unsigned lat;
  } vec_t;
  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  task automatic add(input logic [4:0] code, input bit ent, input logic [15:0] nums,
                     input logic [2:0] cnt, input bit err, input logic [13:0] val,
                     input int unsigned lat);
    vec_t v;
    v.code = code; v.ent = ent; v.nums = nums; v.cnt = cnt;
    v.err = err; v.val = val; v.lat = lat;
    tbl.push_back(v);
  endtask

  // Offer a key at a falling edge once ready; returns 1 time unit after acceptance.
  task automatic press(input logic [4:0] code);
    int unsigned guard;
    guard = 0;
    @(negedge clk);
    while (!key_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!key_ready) check("ready_timeout", 32'(key_ready), 32'd1);
    key_valid = 1'b1;
    key_code  = code;
    @(posedge clk); #1;
    key_valid = 1'b0;
  endtask

  task automatic do_enter(input logic [13:0] exp_val, input int unsigned exp_lat,
                          input logic [15:0] held);
    int unsigned n;
    sb.push_back(VALUE_W'(exp_val));
    press(5'h12);
    check("enter_no_error", 32'(key_error), 32'd0);
    n = 1;
    while (!value_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("enter_latency", 32'(n), 32'(exp_lat));
    check("done_numbers_held", 32'(numbers), 32'(held));
    check("done_not_ready", 32'(key_ready), 32'd0);
    @(posedge clk); #1;
    check("post_numbers", 32'(numbers), 32'd0);
    check("post_count", 32'(digit_count), 32'd0);
    check("post_ready", 32'(key_ready), 32'd1);
    check("post_vv_low", 32'(value_valid), 32'd0);
    check("value_held", 32'(value), 32'(exp_val));
  endtask

  // Scoreboard consumer: every value_valid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && value_valid === 1'b1) begin
      vv_count++;
      check("vv_err_exclusive", 32'(key_error), 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_value_valid", 32'd1, 32'd0);
      end else begin
        check("sb_value", 32'(value), 32'(sb.pop_front()));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total %0d", total);
    $fatal(1);
  end

  initial begin
    logic [15:0] prev;
    int unsigned vv_before;
    int unsigned guard;

    add(5'h01, 0, 16'h0001, 3'd1, 0, 14'd0, 0);
    add(5'h02, 0, 16'h0021, 3'd2, 0, 14'd0, 0);
    add(5'h03, 0, 16'h0321, 3'd3, 0, 14'd0, 0);
    add(5'h04, 0, 16'h4321, 3'd4, 0, 14'd0, 0);
    add(5'h12, 1, 16'h0000, 3'd0, 0, 14'd1234, 5);
    add(5'h09, 0, 16'h0009, 3'd1, 0, 14'd0, 0);
    add(5'h09, 0, 16'h0099, 3'd2, 0, 14'd0, 0);
    add(5'h09, 0, 16'h0999, 3'd3, 0, 14'd0, 0);
    add(5'h09, 0, 16'h9999, 3'd4, 0, 14'd0, 0);
    add(5'h05, 0, 16'h9999, 3'd4, 1, 14'd0, 0);
    add(5'h12, 1, 16'h0000, 3'd0, 0, 14'd9999, 5);
    add(5'h07, 0, 16'h0007, 3'd1, 0, 14'd0, 0);
    add(5'h08, 0, 16'h0087, 3'd2, 0, 14'd0, 0);
    add(5'h10, 0, 16'h0007, 3'd1, 0, 14'd0, 0);
    add(5'h03, 0, 16'h0037, 3'd2, 0, 14'd0, 0);
    add(5'h12, 1, 16'h0000, 3'd0, 0, 14'd73, 3);
    add(5'h10, 0, 16'h0000, 3'd0, 1, 14'd0, 0);
    add(5'h1F, 0, 16'h0000, 3'd0, 1, 14'd0, 0);
    add(5'h11, 0, 16'h0000, 3'd0, 0, 14'd0, 0);
    add(5'h12, 1, 16'h0000, 3'd0, 0, 14'd0, 1);
    add(5'h06, 0, 16'h0006, 3'd1, 0, 14'd0, 0);
    add(5'h0A, 0, 16'h0006, 3'd1, 1, 14'd0, 0);
    add(5'h13, 0, 16'h0006, 3'd1, 1, 14'd0, 0);
    add(5'h11, 0, 16'h0000, 3'd0, 0, 14'd0, 0);

    // Reset behaviour and first ready edge.
    #2 rst_n = 1'b0;
    #1;
    check("rst_numbers", 32'(numbers), 32'd0);
    check("rst_count", 32'(digit_count), 32'd0);
    check("rst_value", 32'(value), 32'd0);
    check("rst_vv", 32'(value_valid), 32'd0);
    check("rst_err", 32'(key_error), 32'd0);
    repeat (3) @(posedge clk);
    #1 check("rst_ready", 32'(key_ready), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    #1 check("release_ready_low", 32'(key_ready), 32'd0);
    @(posedge clk); #1;
    check("first_edge_ready", 32'(key_ready), 32'd1);

    prev = 16'h0000;
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].ent) begin
        do_enter(tbl[i].val, tbl[i].lat, prev);
      end else begin
        press(tbl[i].code);
        check($sformatf("vec%0d_numbers", i), 32'(numbers), 32'(tbl[i].nums));
        check($sformatf("vec%0d_count", i), 32'(digit_count), 32'(tbl[i].cnt));
        check($sformatf("vec%0d_error", i), 32'(key_error), 32'(tbl[i].err));
        if (tbl[i].err) begin
          @(posedge clk); #1;
          check($sformatf("vec%0d_error_width", i), 32'(key_error), 32'd0);
          check($sformatf("vec%0d_unchanged", i), 32'(numbers), 32'(tbl[i].nums));
        end
      end
      prev = tbl[i].nums;
    end

    // Backpressure: a digit held through CONVERT/DONE is accepted exactly once.
    press(5'h04);
    press(5'h02);
    sb.push_back(VALUE_W'(42));
    press(5'h12);
    key_valid = 1'b1;
    key_code  = 5'h03;
    guard = 0;
    @(negedge clk);
    while (!key_ready && guard < 20) begin
      check("bp_numbers_frozen", 32'(numbers), 32'h0024);
      check("bp_count_frozen", 32'(digit_count), 32'd2);
      @(negedge clk);
      guard++;
    end
    check("bp_ready_returns", 32'(key_ready), 32'd1);
    @(posedge clk); #1;
    key_valid = 1'b0;
    check("bp_accept_numbers", 32'(numbers), 32'h0003);
    check("bp_accept_count", 32'(digit_count), 32'd1);
    @(posedge clk); #1;
    check("bp_single_accept", 32'(digit_count), 32'd1);
    press(5'h11);

    // Reset during CONVERT aborts with no value_valid.
    press(5'h05);
    press(5'h06);
    sb.push_back(VALUE_W'(56));
    press(5'h12);
    @(posedge clk); #1;
    check("mid_in_convert", 32'(key_ready), 32'd0);
    vv_before = vv_count;
    #2 rst_n = 1'b0;
    #1;
    sb.delete();
    check("mid_rst_numbers", 32'(numbers), 32'd0);
    check("mid_rst_count", 32'(digit_count), 32'd0);
    check("mid_rst_value", 32'(value), 32'd0);
    check("mid_rst_vv", 32'(value_valid), 32'd0);
    check("mid_rst_err", 32'(key_error), 32'd0);
    check("mid_rst_ready", 32'(key_ready), 32'd0);
    repeat (4) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1 check("mid_release_ready_low", 32'(key_ready), 32'd0);
    @(posedge clk); #1;
    check("mid_release_ready", 32'(key_ready), 32'd1);
    repeat (6) @(posedge clk);
    #1 check("mid_no_value_valid", 32'(vv_count), 32'(vv_before));

    // Normal operation resumes after the aborted conversion.
    press(5'h08);
    do_enter(14'd8, 2, 16'h0008);

    repeat (3) @(posedge clk);
    #1 check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/digit_entry.md
DIGIT_ENTRY -- requirements
Module: digit_entry

Interface
REQ-001 The block SHALL have parameter MAX_DIGITS, default 4, giving the number of BCD digits held; the legal range is 1..7.
REQ-002 The block SHALL have parameter VALUE_W, default 14, giving the binary result width; it must hold 10^MAX_DIGITS-1.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port key_valid, input, 1 bit: a key code is offered.
REQ-006 The block SHALL have port key_code, input, 5 bits, with these codes:
- 0x00-0x09: digit
- 0x10: backspace
- 0x11: clear
- 0x12: enter
- all others: invalid
REQ-007 The block SHALL have port key_ready, output, 1 bit: the block can accept a key this cycle.
REQ-008 The block SHALL have port numbers, output, 4*MAX_DIGITS bits: BCD digit buffer for the display. Nibble 0 holds the first-typed (leftmost) digit.
REQ-009 The block SHALL have port digit_count, output, 3 bits: the number of digits held, 0..MAX_DIGITS.
REQ-010 The block SHALL have port value, output, VALUE_W bits: the binary value of the last entered number.
REQ-011 The block SHALL have port value_valid, output, 1 bit: a one-cycle pulse when value updates.
REQ-012 The block SHALL have port key_error, output, 1 bit: a one-cycle pulse when an accepted key is rejected.

Function
REQ-013 A key SHALL be accepted on a rising clk edge where key_valid=1 and key_ready=1; key_valid with key_ready=0 SHALL have no effect, and the source holds the key.
REQ-014 The block SHALL implement FSM states IDLE, CONVERT and DONE; key_ready SHALL be 1 only in IDLE.
REQ-015 A digit key accepted in IDLE with digit_count<MAX_DIGITS SHALL write numbers[4*digit_count +:4]=key_code[3:0] and increment digit_count, both visible the next cycle.
REQ-016 A digit key accepted with digit_count==MAX_DIGITS SHALL leave numbers and digit_count unchanged and pulse key_error for 1 cycle.
REQ-017 A backspace key with digit_count>0 SHALL zero nibble digit_count-1 and decrement digit_count; with digit_count==0 it SHALL pulse key_error and change nothing.
REQ-018 A clear key SHALL zero numbers and digit_count in one cycle, with no error even if already empty.
REQ-019 An invalid code SHALL pulse key_error and change no other state.
REQ-020 Nibbles at index >= digit_count SHALL always read 0.
REQ-021 An enter key with digit_count>0 SHALL move the FSM to CONVERT, clear the accumulator and clear the digit index i.
REQ-022 In CONVERT, each cycle SHALL compute acc=acc*10+numbers[4*i +:4] and then i=i+1.
REQ-023 After digit_count CONVERT cycles the FSM SHALL move to DONE.
REQ-024 An enter key with digit_count==0 SHALL move the FSM directly to DONE with an accumulator of 0.
REQ-025 In DONE, value SHALL be loaded from the accumulator, value_valid SHALL be 1 for exactly that cycle, and the next edge SHALL zero numbers and digit_count and return the FSM to IDLE.
REQ-026 Enter-to-value_valid latency SHALL be digit_count+1 cycles after the acceptance edge.
REQ-027 value_valid SHALL be high in the last non-ready cycle.
REQ-028 numbers and digit_count SHALL stay constant during CONVERT and DONE.
REQ-029 value SHALL hold its last result until the next DONE.
REQ-030 The accumulator SHALL be VALUE_W bits with no overflow possible given REQ-002; digits are never >9 because only codes 0x00-0x09 are stored.
REQ-031 key_error and value_valid SHALL never be high in the same cycle.

Reset
REQ-032 While rst_n=0, the block SHALL asynchronously force state IDLE, numbers=0, digit_count=0, value=0, value_valid=0, key_error=0 and key_ready=0.
REQ-033 key_ready SHALL rise on the first clk edge after rst_n deasserts.
REQ-034 A reset asserted during CONVERT or DONE SHALL abort the conversion with no value_valid pulse.

Verification
REQ-035 The bench SHALL cover entry: keys 1,2,3,4 then enter -> numbers=0x4321 and digit_count=4 before enter; value_valid 5 cycles after the enter edge with value=1234; then numbers=0 and digit_count=0.
REQ-036 The bench SHALL cover overflow: keys 9,9,9,9,5 -> the fifth key gives key_error=1 for 1 cycle and numbers stays 0x9999; enter -> value=9999.
REQ-037 The bench SHALL cover editing: keys 7,8, backspace, 3, enter -> numbers=0x0037 before enter; value=73 after 3 cycles.
REQ-038 The bench SHALL cover empty-buffer keys: backspace on empty -> key_error pulse; enter on empty -> value_valid after 1 cycle with value=0; code 0x1F -> key_error, no state change.
REQ-039 The bench SHALL cover backpressure: key_valid held through CONVERT -> no acceptance until key_ready=1, then exactly one acceptance.
REQ-040 The bench SHALL cover reset mid-operation: rst_n pulled low during CONVERT after keys 5,6 -> all outputs 0 immediately, no value_valid, and key_ready=1 one edge after release.
